// File: rtl/alu_arb_pkg.sv
// Shared types for the shared-ALU arbiter: ALU opcodes,
// flag bundle, request bundle and arbiter FSM states.
package alu_arb_pkg;

    localparam int ALU_FLAGS_W = 4;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLT  = 4'h5;
    localparam logic [3:0] ALU_SLTU = 4'h6;
    localparam logic [3:0] ALU_SLL  = 4'h7;
    localparam logic [3:0] ALU_SRL  = 4'h8;
    localparam logic [3:0] ALU_SRA  = 4'h9;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } alu_req_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/alu_32bit.sv
// Combinational 32-bit ALU with {N,Z,C,V} flags.
// C is carry-out (SUB: 1 = no borrow); C,V only for ADD/SUB.
module alu_32bit
    import alu_arb_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o,
    output alu_flags_t  flags_o
);

    logic        is_sub;
    logic        is_arith;
    logic [31:0] b_eff;
    logic [32:0] sum;

    // Shared adder: SUB is a + ~b + 1
    always_comb begin
        is_sub   = (op_i == ALU_SUB);
        is_arith = (op_i == ALU_ADD) || is_sub;
        b_eff    = is_sub ? ~b_i : b_i;
        sum      = {1'b0, a_i} + {1'b0, b_eff} + {32'd0, is_sub};
    end

    // Result select; undefined opcodes give zero
    always_comb begin
        result_o = 32'd0;
        case (op_i)
            ALU_ADD:  result_o = sum[31:0];
            ALU_SUB:  result_o = sum[31:0];
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLT:  result_o = {31'd0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {31'd0, a_i < b_i};
            ALU_SLL:  result_o = a_i << b_i[4:0];
            ALU_SRL:  result_o = a_i >> b_i[4:0];
            ALU_SRA:  result_o = 32'($signed(a_i) >>> b_i[4:0]);
            default:  result_o = 32'd0;
        endcase
    end

    // Flags derived from the selected result
    always_comb begin
        flags_o.n = result_o[31];
        flags_o.z = (result_o == 32'd0);
        flags_o.c = is_arith & sum[32];
        flags_o.v = is_arith & (a_i[31] == b_eff[31])
                             & (result_o[31] != a_i[31]);
    end

endmodule

// File: rtl/alu_share_arb_rr.sv
// Round-robin picker: first set request at or above ptr,
// otherwise first set request below ptr.
module rr_arb #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic found;

    // Two passes: upper segment from ptr, then wrap to 0
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        any_o = |req_i;
        for (int j = 0; j < N; j++) begin
            if (!found && req_i[j] && (j >= int'(ptr_i))) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// One ALU shared by NUM_REQ requesters; round-robin grants,
// registered result/flags held until the owner accepts.
module alu_share_arb
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*4-1:0]   req_op,
    input  logic [NUM_REQ*32-1:0]  req_a,
    input  logic [NUM_REQ*32-1:0]  req_b,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [31:0]            rsp_result,
    output logic [ALU_FLAGS_W-1:0] rsp_flags,
    output logic [ID_W-1:0]        rsp_id
);

    arb_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]   valid_q, valid_d;
    logic [31:0]          result_q, result_d;
    alu_flags_t           flags_q, flags_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;

    alu_req_t             reqs [NUM_REQ];
    alu_req_t             sel;
    logic [NUM_REQ-1:0]   gnt_oh;
    logic [ID_W-1:0]      gnt_idx;
    logic                 gnt_any;
    logic                 slot_free;
    logic                 accept;
    logic [31:0]          alu_res;
    alu_flags_t           alu_flags;

    // Unpack the flat request buses into per-requester bundles
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqs[i].op = req_op[4*i +: 4];
            reqs[i].a  = req_a[32*i +: 32];
            reqs[i].b  = req_b[32*i +: 32];
        end
    end

    rr_arb #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt_oh),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    // Slot frees when idle or when the owner drains this cycle
    always_comb begin
        slot_free = (state_q == ST_IDLE) ||
                    ((state_q == ST_HOLD) && rsp_ready[id_q]);
        accept    = slot_free && gnt_any && !rst;
        req_ready = accept ? gnt_oh : '0;
        sel       = reqs[gnt_idx];
    end

    alu_32bit u_alu (
        .op_i     (sel.op),
        .a_i      (sel.a),
        .b_i      (sel.b),
        .result_o (alu_res),
        .flags_o  (alu_flags)
    );

    // Next state: new grant overrides drain (back-to-back responses)
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        result_d = result_q;
        flags_d  = flags_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        if (accept) begin
            state_d  = ST_HOLD;
            valid_d  = gnt_oh;
            result_d = alu_res;
            flags_d  = alu_flags;
            id_d     = gnt_idx;
            ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ?
                       '0 : gnt_idx + 1'b1;
        end else if ((state_q == ST_HOLD) && rsp_ready[id_q]) begin
            state_d = ST_IDLE;
            valid_d = '0;
        end
    end

    // State and response registers; reset drops any held response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            valid_q  <= '0;
            result_q <= '0;
            flags_q  <= '0;
            id_q     <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            id_q     <= id_d;
            ptr_q    <= ptr_d;
        end
    end

    assign rsp_valid  = valid_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign rsp_id     = id_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: table of per-cycle vectors
// plus a reset-during-hold sequence.
module tb_alu_share_arb;
    import alu_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [0:0]  rsp_id;

    int errors = 0;
    int checks = 0;

    alu_share_arb #(.NUM_REQ(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_id     (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rv;
        logic [1:0]  rr;
        logic [3:0]  op0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [3:0]  op1;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [1:0]  e_rdy;
        logic [1:0]  e_val;
        logic [31:0] e_res;
        logic [3:0]  e_flg;
        logic        e_id;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(
        input logic [1:0] rv, input logic [1:0] rr,
        input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
        input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
        input logic [1:0] e_rdy, input logic [1:0] e_val,
        input logic [31:0] e_res, input logic [3:0] e_flg, input logic e_id);
        vec_t v;
        v.rv = rv; v.rr = rr;
        v.op0 = op0; v.a0 = a0; v.b0 = b0;
        v.op1 = op1; v.a1 = a1; v.b1 = b1;
        v.e_rdy = e_rdy; v.e_val = e_val;
        v.e_res = e_res; v.e_flg = e_flg; v.e_id = e_id;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        req_valid = v.rv;
        rsp_ready = v.rr;
        req_op    = {v.op1, v.op0};
        req_a     = {v.a1, v.a0};
        req_b     = {v.b1, v.b0};
    endtask

    initial begin
        // single op, then round-robin 0,1,0,1 with ptr starting at 0
        vecs[0]  = mk(2'b11, 2'b11, ALU_ADD, 7, 5, ALU_ADD, 3, 4,
                      2'b01, 2'b00, 0, 4'h0, 0);
        vecs[1]  = mk(2'b10, 2'b11, ALU_ADD, 7, 5, ALU_ADD, 3, 4,
                      2'b10, 2'b01, 12, 4'h0, 0);
        vecs[2]  = mk(2'b11, 2'b11, ALU_ADD, 1, 1, ALU_ADD, 10, 10,
                      2'b01, 2'b10, 7, 4'h0, 1);
        vecs[3]  = mk(2'b11, 2'b11, ALU_ADD, 2, 2, ALU_ADD, 10, 10,
                      2'b10, 2'b01, 2, 4'h0, 0);
        vecs[4]  = mk(2'b11, 2'b11, ALU_ADD, 2, 2, ALU_ADD, 20, 20,
                      2'b01, 2'b10, 20, 4'h0, 1);
        vecs[5]  = mk(2'b11, 2'b11, ALU_ADD, 3, 3, ALU_ADD, 20, 20,
                      2'b10, 2'b01, 4, 4'h0, 0);
        // backpressure on requester 1; rsp_ready[0] must be ignored
        vecs[6]  = mk(2'b10, 2'b11, ALU_ADD, 3, 3,
                      ALU_SUB, 32'h8000_0000, 1,
                      2'b10, 2'b10, 40, 4'h0, 1);
        for (int i = 7; i < 10; i++)
            vecs[i] = mk(2'b11, 2'b01, ALU_ADD, 5, 6,
                         ALU_SUB, 32'h8000_0000, 1,
                         2'b00, 2'b10, 32'h7FFF_FFFF, 4'h3, 1);
        vecs[10] = mk(2'b11, 2'b11, ALU_ADD, 5, 6,
                      ALU_SUB, 32'h8000_0000, 1,
                      2'b01, 2'b10, 32'h7FFF_FFFF, 4'h3, 1);
        vecs[11] = mk(2'b00, 2'b11, ALU_ADD, 0, 0, ALU_ADD, 0, 0,
                      2'b00, 2'b01, 11, 4'h0, 0);
        // edge ops, single requester granted every cycle
        vecs[12] = mk(2'b01, 2'b11, ALU_SLTU, 1, 32'hFFFF_FFFF,
                      ALU_ADD, 0, 0, 2'b01, 2'b00, 0, 4'h0, 0);
        vecs[13] = mk(2'b01, 2'b11, ALU_SUB, 5, 5, ALU_ADD, 0, 0,
                      2'b01, 2'b01, 1, 4'h0, 0);
        vecs[14] = mk(2'b01, 2'b11, ALU_ADD, 32'hFFFF_FFFF, 1,
                      ALU_ADD, 0, 0, 2'b01, 2'b01, 0, 4'h6, 0);
        vecs[15] = mk(2'b01, 2'b11, 4'hF, 9, 3, ALU_ADD, 0, 0,
                      2'b01, 2'b01, 0, 4'h6, 0);
        vecs[16] = mk(2'b00, 2'b11, ALU_ADD, 0, 0, ALU_ADD, 0, 0,
                      2'b00, 2'b01, 0, 4'h4, 0);
        vecs[17] = mk(2'b00, 2'b11, ALU_ADD, 0, 0, ALU_ADD, 0, 0,
                      2'b00, 2'b00, 0, 4'h0, 0);

        // reset held two cycles with both requesters valid
        rst       = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("rst%0d req_ready", c), 32'(req_ready), 0);
            chk($sformatf("rst%0d rsp_valid", c), 32'(rsp_valid), 0);
            chk($sformatf("rst%0d rsp_result", c), rsp_result, 0);
            chk($sformatf("rst%0d rsp_flags", c), 32'(rsp_flags), 0);
        end
        rst       = 1'b0;
        req_valid = 2'b00;

        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            #1;
            apply(vecs[i]);
            @(negedge clk);
            chk($sformatf("r%0d req_ready", i),
                32'(req_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("r%0d rsp_valid", i),
                32'(rsp_valid), 32'(vecs[i].e_val));
            if (vecs[i].e_val != 2'b00) begin
                chk($sformatf("r%0d rsp_result", i),
                    rsp_result, vecs[i].e_res);
                chk($sformatf("r%0d rsp_flags", i),
                    32'(rsp_flags), 32'(vecs[i].e_flg));
                chk($sformatf("r%0d rsp_id", i),
                    32'(rsp_id), 32'(vecs[i].e_id));
            end
        end

        // reset while a response is held; ptr must return to 0
        @(posedge clk);
        #1;
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        req_op    = {ALU_ADD, ALU_ADD};
        req_a     = {32'd0, 32'd1};
        req_b     = {32'd0, 32'd2};
        @(negedge clk);
        chk("mh grant0", 32'(req_ready), 32'b01);

        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rst       = 1'b1;
        @(negedge clk);
        chk("mh held valid", 32'(rsp_valid), 32'b01);
        chk("mh held result", rsp_result, 3);
        chk("mh rst req_ready", 32'(req_ready), 0);

        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        req_a     = {32'd200, 32'd100};
        req_b     = {32'd1, 32'd1};
        @(negedge clk);
        chk("mh post valid", 32'(rsp_valid), 0);
        chk("mh post result", rsp_result, 0);
        chk("mh post flags", 32'(rsp_flags), 0);
        chk("mh post id", 32'(rsp_id), 0);
        chk("mh ptr0 grant", 32'(req_ready), 32'b01);

        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("mh fresh valid", 32'(rsp_valid), 32'b01);
        chk("mh fresh result", rsp_result, 101);
        chk("mh fresh id", 32'(rsp_id), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
